// File: rtl/axis_512_to_320_gearbox.sv
// rtl/axis_512_to_320_gearbox.sv - 512-bit to 320-bit byte-packing stream gearbox
//
// Repacks byte-contiguous 64 B input beats into gap-free 40 B output beats.
// Packet boundaries are kept: two packets never share an output beat.
//
// Ports:
//   user_clk, user_aresetn         clock, async active-low reset
//   s_axis_t{valid,ready,data,keep,last}  512-bit input stream
//   m_axis_t{valid,ready,data,keep,last}  320-bit output stream
//   bytes_in, beats_out            wrapping statistics counters
module axis_512_to_320_gearbox #(
  parameter int CNT_W     = 32,
  parameter int IN_BYTES  = 64,
  parameter int OUT_BYTES = 40
) (
  input  logic                    user_clk,
  input  logic                    user_aresetn,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [IN_BYTES*8-1:0]   s_axis_tdata,
  input  logic [IN_BYTES-1:0]     s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [OUT_BYTES*8-1:0]  m_axis_tdata,
  output logic [OUT_BYTES-1:0]    m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [CNT_W-1:0]        bytes_in,
  output logic [CNT_W-1:0]        beats_out
);

  localparam int BUF_BYTES = 2 * IN_BYTES;
  localparam int LVL_W     = $clog2(BUF_BYTES + 1);
  localparam int NIN_W     = $clog2(IN_BYTES + 1);
  localparam int NOUT_W    = $clog2(OUT_BYTES + 1);

  // Byte 0 of buf_q is the next byte to leave; bytes at and above lvl_q are kept zero.
  logic [BUF_BYTES*8-1:0] buf_q;
  logic [LVL_W-1:0]       lvl_q;
  logic                   flush_q;
  logic [CNT_W-1:0]       bytes_in_q;
  logic [CNT_W-1:0]       beats_out_q;

  logic [NIN_W-1:0]       nin;
  logic [NOUT_W-1:0]      nout;
  logic [NOUT_W-1:0]      drain;
  logic [LVL_W-1:0]       wr_off;
  logic [IN_BYTES*8-1:0]  in_masked;
  logic [BUF_BYTES*8-1:0] buf_d;
  logic [LVL_W-1:0]       lvl_d;
  logic                   in_fire;
  logic                   out_fire;
  logic [OUT_BYTES:0]     keep_wide;

  always_comb begin
    nin = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      nin = nin + NIN_W'(s_axis_tkeep[i]);
    end
  end

  always_comb begin
    in_masked = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      in_masked[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
    end
  end

  // Ready and valid depend only on registered state, so there is no combinational
  // path from m_axis_tready to s_axis_tready.
  assign s_axis_tready = user_aresetn && !flush_q && (lvl_q <= LVL_W'(IN_BYTES));
  // flush with an empty buffer still yields one keep=0 beat carrying tlast.
  assign m_axis_tvalid = (lvl_q >= LVL_W'(OUT_BYTES)) || flush_q;
  assign m_axis_tlast  = flush_q && (lvl_q <= LVL_W'(OUT_BYTES));

  assign nout      = (lvl_q >= LVL_W'(OUT_BYTES)) ? NOUT_W'(OUT_BYTES) : NOUT_W'(lvl_q);
  assign keep_wide = ((OUT_BYTES+1)'(1) << nout) - (OUT_BYTES+1)'(1);
  assign m_axis_tkeep = keep_wide[OUT_BYTES-1:0];

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      m_axis_tdata[8*i +: 8] = m_axis_tkeep[i] ? buf_q[8*i +: 8] : 8'h00;
    end
  end

  assign in_fire  = s_axis_tvalid && s_axis_tready;
  assign out_fire = m_axis_tvalid && m_axis_tready;
  assign drain    = out_fire ? nout : '0;
  // New bytes land right after whatever survives this cycle's drain.
  assign wr_off   = lvl_q - LVL_W'(drain);

  always_comb begin
    buf_d = buf_q >> {drain, 3'b000};
    if (in_fire) begin
      buf_d = buf_d | ({{(BUF_BYTES-IN_BYTES)*8{1'b0}}, in_masked} << {wr_off, 3'b000});
    end
  end

  assign lvl_d = wr_off + (in_fire ? LVL_W'(nin) : '0);

  always_ff @(posedge user_clk or negedge user_aresetn) begin
    if (!user_aresetn) begin
      buf_q       <= '0;
      lvl_q       <= '0;
      flush_q     <= 1'b0;
      bytes_in_q  <= '0;
      beats_out_q <= '0;
    end else begin
      buf_q <= buf_d;
      lvl_q <= lvl_d;
      // Set and clear are exclusive: input only fires while flush_q is low,
      // and a tlast output only exists while flush_q is high.
      if (out_fire && m_axis_tlast) begin
        flush_q <= 1'b0;
      end else if (in_fire && s_axis_tlast) begin
        flush_q <= 1'b1;
      end
      if (in_fire) begin
        bytes_in_q <= bytes_in_q + CNT_W'(nin);
      end
      if (out_fire) begin
        beats_out_q <= beats_out_q + CNT_W'(1);
      end
    end
  end

  assign bytes_in  = bytes_in_q;
  assign beats_out = beats_out_q;

endmodule

// File: tb/tb_axis_512_to_320_gearbox.sv
// tb/tb_axis_512_to_320_gearbox.sv - self-checking bench for axis_512_to_320_gearbox
module tb_axis_512_to_320_gearbox;

  logic         user_clk = 1'b0;
  logic         user_aresetn;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [319:0] m_axis_tdata;
  logic [39:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [31:0]  bytes_in;
  logic [31:0]  beats_out;

  always #5 user_clk = ~user_clk;

  axis_512_to_320_gearbox #(.CNT_W(32), .IN_BYTES(64), .OUT_BYTES(40)) dut (
    .user_clk      (user_clk),
    .user_aresetn  (user_aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .bytes_in      (bytes_in),
    .beats_out     (beats_out)
  );

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } in_beat_t;

  typedef struct packed {
    logic [319:0] d;
    logic [39:0]  k;
    logic         l;
  } out_beat_t;

  in_beat_t    stim_q[$];
  out_beat_t   exp_q[$];
  logic [7:0]  pend[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_bytes = 0;
  int          exp_beats = 0;
  int          sink_mode = 0;
  int          stall_lo = 0;
  int          stall_hi = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [63:0] k);
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(k[i]);
    return n;
  endfunction

  // Reference: a packet is just a byte string cut into 40-byte pieces from its start.
  task automatic emit_chunk(input int n, input logic last);
    out_beat_t o;
    o = '0;
    for (int i = 0; i < n; i++) begin
      o.d[8*i +: 8] = pend.pop_front();
      o.k[i] = 1'b1;
    end
    o.l = last;
    exp_q.push_back(o);
    exp_beats++;
  endtask

  task automatic add_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    in_beat_t b;
    int n;
    b.d = d; b.k = k; b.l = l;
    stim_q.push_back(b);
    n = popc(k);
    exp_bytes += n;
    for (int i = 0; i < n; i++) pend.push_back(d[8*i +: 8]);
    if (l) begin
      if (pend.size() == 0) emit_chunk(0, 1'b1);
      while (pend.size() > 0) begin
        if (pend.size() <= 40) emit_chunk(pend.size(), 1'b1);
        else emit_chunk(40, 1'b0);
      end
    end
  endtask

  // Packet cut short by reset: only complete 40-byte pieces ever leave.
  task automatic drop_partial();
    while (pend.size() >= 40) emit_chunk(40, 1'b0);
    pend.delete();
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] keep_of(input int n);
    logic [63:0] k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  task automatic rand_packet(input int nbeats);
    int n;
    for (int b = 0; b < nbeats; b++) begin
      n = ($urandom_range(0, 9) < 7) ? 64 : int'($urandom_range(0, 64));
      // A byteless last beat after an exact multiple of 40 makes tlast placement
      // timing-dependent; keep it out of random traffic.
      if (b == nbeats - 1 && n == 0 && pend.size() > 0 && (pend.size() % 40) == 0) n = 1;
      add_beat(rand_data(), keep_of(n), logic'(b == nbeats - 1));
    end
  endtask

  task automatic run(input int budget);
    int        idx = 0;
    int        c = 0;
    logic      hold = 1'b0;
    out_beat_t held;
    out_beat_t o;
    while ((idx < stim_q.size() || exp_q.size() > 0) && c < budget) begin
      @(negedge user_clk);
      c++;
      if (idx < stim_q.size() && (sink_mode != 1 || $urandom_range(0, 3) != 0)) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = stim_q[idx].d;
        s_axis_tkeep  = stim_q[idx].k;
        s_axis_tlast  = stim_q[idx].l;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      case (sink_mode)
        1:       m_axis_tready = ($urandom_range(0, 9) < 6);
        2:       m_axis_tready = !(c >= stall_lo && c <= stall_hi);
        default: m_axis_tready = 1'b1;
      endcase
      #1;
      if (hold) begin
        check("hold_valid", m_axis_tvalid, 1'b1);
        check("hold_data", m_axis_tdata, held.d);
        check("hold_keep", m_axis_tkeep, held.k);
        check("hold_last", m_axis_tlast, held.l);
      end
      if (sink_mode == 2 && c == stall_hi) begin
        check("stall_s_ready_low", s_axis_tready, 1'b0);
        check("stall_m_valid", m_axis_tvalid, 1'b1);
      end
      hold = m_axis_tvalid && !m_axis_tready;
      held.d = m_axis_tdata; held.k = m_axis_tkeep; held.l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          o = exp_q.pop_front();
          check("out_data", m_axis_tdata, o.d);
          check("out_keep", m_axis_tkeep, o.k);
          check("out_last", m_axis_tlast, o.l);
        end
      end
      if (s_axis_tvalid && s_axis_tready) idx++;
    end
    check("run_in_budget", logic'(c < budget), 1'b1);
    @(posedge user_clk);
    #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_axis_tready, 1'b0);
    check({tag, "_m_valid"}, m_axis_tvalid, 1'b0);
    check({tag, "_m_data"}, m_axis_tdata, '0);
    check({tag, "_m_keep"}, m_axis_tkeep, '0);
    check({tag, "_m_last"}, m_axis_tlast, 1'b0);
    check({tag, "_bytes_in"}, bytes_in, '0);
    check({tag, "_beats_out"}, beats_out, '0);
  endtask

  initial begin
    logic [511:0] d;
    user_aresetn  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge user_clk);
    user_aresetn = 1'b1;
    #1;
    check("post_reset_s_ready", s_axis_tready, 1'b1);
    check("post_reset_m_valid", m_axis_tvalid, 1'b0);

    // Single full beat with last: 40 B then 24 B.
    sink_mode = 0;
    add_beat(rand_data(), '1, 1'b1);
    run(200);
    check("t1_bytes_in", bytes_in, 64);
    check("t1_beats_out", beats_out, 2);

    // Five 64 B beats with an incrementing byte pattern: eight full beats.
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'((b * 64 + i) & 255);
      add_beat(d, '1, logic'(b == 4));
    end
    run(200);

    // Eight-byte packet.
    add_beat(rand_data(), 64'hFF, 1'b1);
    run(200);

    // 64 B without last, then an empty last beat.
    add_beat(rand_data(), '1, 1'b0);
    add_beat(rand_data(), '0, 1'b1);
    run(200);

    // Empty single-beat packet.
    add_beat(rand_data(), '0, 1'b1);
    run(200);

    // 20-cycle downstream stall in the middle of a long packet.
    sink_mode = 2;
    stall_lo  = 4;
    stall_hi  = 23;
    rand_packet(6);
    run(400);

    // Random packets with random gaps and back-pressure.
    sink_mode = 1;
    for (int p = 0; p < 12; p++) rand_packet(int'($urandom_range(1, 5)));
    run(3000);
    check("rand_bytes_in", bytes_in, 32'(exp_bytes));
    check("rand_beats_out", beats_out, 32'(exp_beats));

    // Reset with 24 B still buffered, then a fresh packet.
    sink_mode = 0;
    add_beat(rand_data(), '1, 1'b0);
    drop_partial();
    run(200);
    #2;
    user_aresetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_bytes = 0;
    exp_beats = 0;
    repeat (2) @(negedge user_clk);
    user_aresetn = 1'b1;
    #1;
    check("t6_idle_valid", m_axis_tvalid, 1'b0);
    add_beat(rand_data(), '1, 1'b1);
    run(200);
    check("t6_bytes_in", bytes_in, 32'(exp_bytes));
    check("t6_beats_out", beats_out, 32'(exp_beats));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
